// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared constants for the UART command controller: opcodes,
//                reply bytes, header field positions and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef logic [1:0] opcode_t;
    typedef logic [2:0] state_t;

    localparam opcode_t c_op_ping   = 2'b00;
    localparam opcode_t c_op_run    = 2'b01;
    localparam opcode_t c_op_status = 2'b10;
    localparam opcode_t c_op_abort  = 2'b11;

    localparam logic [7:0] c_ack_byte = 8'h06;
    localparam logic [7:0] c_nak_byte = 8'h15;

    localparam int c_hdr_op_msb  = 7;
    localparam int c_hdr_op_lsb  = 6;
    localparam int c_hdr_rsv_msb = 5;
    localparam int c_hdr_rsv_lsb = 3;
    localparam int c_hdr_ch_msb  = 2;
    localparam int c_hdr_ch_lsb  = 0;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_payload = 3'd1;
    localparam state_t c_st_check   = 3'd2;
    localparam state_t c_st_exec    = 3'd3;
    localparam state_t c_st_tx      = 3'd4;

    // A header is refused outright on nonzero reserved bits or an absent channel.
    function automatic logic hdr_invalid(input logic [7:0] hdr, input int channels);
        logic [2:0] ch;
        ch = hdr[c_hdr_ch_msb:c_hdr_ch_lsb];
        return (hdr[c_hdr_rsv_msb:c_hdr_rsv_lsb] != 3'b000) || (int'(ch) >= channels);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl_if
//  Description : Byte receiver/transmitter handshake plus per-channel engine
//                control bundle. master = controller, slave = peer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_ctrl_if #(
    parameter int Channels     = 4,
    parameter int PayloadBytes = 2
);
    logic                      rx_valid_i;
    logic [7:0]                rx_data_i;
    logic                      tx_stt_o;
    logic [7:0]                tx_data_o;
    logic                      tx_eot_i;
    logic [Channels-1:0]       start_o;
    logic [Channels-1:0]       abort_o;
    logic [8*PayloadBytes-1:0] arg_o;
    logic [Channels-1:0]       done_i;
    logic [Channels-1:0]       busy_o;
    logic                      err_o;

    modport master (
        input  rx_valid_i, rx_data_i, tx_eot_i, done_i,
        output tx_stt_o, tx_data_o, start_o, abort_o, arg_o, busy_o, err_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, tx_eot_i, done_i,
        input  tx_stt_o, tx_data_o, start_o, abort_o, arg_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/cmd_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_timeout
//  Description : Loadable down-counter; pulses expire_o when an enabled count
//                runs out without a reload.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout #(
    parameter int TimeoutBits   = 20,
    parameter int TimeoutCycles = 1_000_000
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic load_i,
    input  wire logic en_i,
    output logic      expire_o
);
    logic [TimeoutBits-1:0] count_q;
    logic [TimeoutBits-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = TimeoutBits'(TimeoutCycles);
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - TimeoutBits'(1);
        end
    end

    // A reload in the final cycle wins, so a byte exactly at the limit is kept.
    assign expire_o = en_i && !load_i && (count_q == TimeoutBits'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl
//  Description : UART frame parser launching/aborting start/done engines with
//                one reply byte per frame. Optional trailing XOR checksum when
//                UART_CMD_CHECKSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int Channels      = 4,
    parameter int PayloadBytes  = 2,
    parameter int TimeoutCycles = 1_000_000,
    parameter int TimeoutBits   = 20
) (
    input wire logic        clk_i,
    input wire logic        rst_i,
    uart_cmd_ctrl_if.master bus
);
    localparam int ArgW = 8 * PayloadBytes;

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t c_frame_end = c_st_check;
`else
    localparam state_t c_frame_end = c_st_exec;
`endif

    state_t              state_q, state_d;
    opcode_t             op_q, op_d;
    logic [2:0]          ch_q, ch_d;
    logic                nak_q, nak_d;
    logic [2:0]          pcnt_q, pcnt_d;
    logic [ArgW-1:0]     payload_q, payload_d;
    logic [ArgW-1:0]     arg_q, arg_d;
    logic [Channels-1:0] busy_q, busy_d;
    logic [Channels-1:0] start_q, start_d;
    logic [Channels-1:0] abort_q, abort_d;
    logic                tx_stt_q, tx_stt_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                err_q, err_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                w_hdr_bad;
    opcode_t             w_hdr_op;
    logic                w_last_pl;
    logic [Channels-1:0] w_ch_oh;
    logic                w_tmr_en;
    logic                w_tmr_expire;

    assign w_hdr_op  = bus.rx_data_i[c_hdr_op_msb:c_hdr_op_lsb];
    assign w_hdr_bad = hdr_invalid(bus.rx_data_i, Channels);
    assign w_last_pl = (pcnt_q == 3'(PayloadBytes - 1));
    assign w_ch_oh   = Channels'(1) << ch_q;
`ifdef UART_CMD_CHECKSUM_EN
    assign w_tmr_en  = (state_q == c_st_payload) || (state_q == c_st_check);
`else
    assign w_tmr_en  = (state_q == c_st_payload);
`endif

    cmd_timeout #(
        .TimeoutBits   (TimeoutBits),
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (bus.rx_valid_i),
        .en_i     (w_tmr_en),
        .expire_o (w_tmr_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (bus.rx_valid_i) begin
                    if (w_hdr_bad) begin
                        state_d = c_st_exec;
                    end else if (w_hdr_op == c_op_run) begin
                        state_d = c_st_payload;
                    end else begin
                        state_d = c_frame_end;
                    end
                end
            end
            c_st_payload: begin
                if (w_tmr_expire) begin
                    state_d = c_st_idle;
                end else if (bus.rx_valid_i && w_last_pl) begin
                    state_d = c_frame_end;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            c_st_check: begin
                if (w_tmr_expire) begin
                    state_d = c_st_idle;
                end else if (bus.rx_valid_i) begin
                    state_d = c_st_exec;
                end
            end
`endif
            c_st_exec: state_d = c_st_tx;
            c_st_tx: begin
                if (bus.tx_eot_i) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        ch_d      = ch_q;
        nak_d     = nak_q;
        pcnt_d    = pcnt_q;
        payload_d = payload_q;
        arg_d     = arg_q;
        tx_data_d = tx_data_q;
        tx_stt_d  = 1'b0;
        start_d   = '0;
        abort_d   = '0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        err_d     = w_tmr_expire ||
                    (bus.rx_valid_i && ((state_q == c_st_exec) || (state_q == c_st_tx)));
        case (state_q)
            c_st_idle: begin
                if (bus.rx_valid_i) begin
                    op_d   = w_hdr_op;
                    ch_d   = bus.rx_data_i[c_hdr_ch_msb:c_hdr_ch_lsb];
                    nak_d  = w_hdr_bad;
                    pcnt_d = 3'd0;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d = bus.rx_data_i;
`endif
                end
            end
            c_st_payload: begin
                if (bus.rx_valid_i) begin
                    payload_d = (payload_q << 8) | ArgW'(bus.rx_data_i);
                    pcnt_d    = pcnt_q + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d    = csum_q ^ bus.rx_data_i;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            c_st_check: begin
                if (bus.rx_valid_i) begin
                    nak_d = nak_q || (bus.rx_data_i != csum_q);
                end
            end
`endif
            c_st_exec: begin
                tx_stt_d = 1'b1;
                if (nak_q) begin
                    tx_data_d = c_nak_byte;
                end else begin
                    case (op_q)
                        c_op_ping: tx_data_d = c_ack_byte;
                        c_op_run: begin
                            if ((busy_q & w_ch_oh) != '0) begin
                                tx_data_d = c_nak_byte;
                            end else begin
                                arg_d     = payload_q;
                                start_d   = w_ch_oh;
                                tx_data_d = c_ack_byte;
                            end
                        end
                        c_op_status: tx_data_d = 8'(busy_q);
                        c_op_abort: begin
                            abort_d   = w_ch_oh;
                            tx_data_d = c_ack_byte;
                        end
                        default: tx_data_d = c_nak_byte;
                    endcase
                end
            end
            default: ;
        endcase
        // Start beats a coincident done; abort beats everything.
        busy_d = ((busy_q & ~bus.done_i) | start_d) & ~abort_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= c_op_ping;
            ch_q      <= 3'd0;
            nak_q     <= 1'b0;
            pcnt_q    <= 3'd0;
            payload_q <= '0;
            arg_q     <= '0;
            busy_q    <= '0;
            start_q   <= '0;
            abort_q   <= '0;
            tx_stt_q  <= 1'b0;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            op_q      <= op_d;
            ch_q      <= ch_d;
            nak_q     <= nak_d;
            pcnt_q    <= pcnt_d;
            payload_q <= payload_d;
            arg_q     <= arg_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            tx_stt_q  <= tx_stt_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign bus.tx_stt_o  = tx_stt_q;
    assign bus.tx_data_o = tx_data_q;
    assign bus.start_o   = start_q;
    assign bus.abort_o   = abort_q;
    assign bus.arg_o     = arg_q;
    assign bus.busy_o    = busy_q;
    assign bus.err_o     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_ctrl
//  Description : Directed self-checking bench for uart_cmd_ctrl (both
//                UART_CMD_CHECKSUM_EN settings).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
    localparam int CH = 4;
    localparam int PB = 2;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.Channels(CH), .PayloadBytes(PB)) bus ();

    uart_cmd_ctrl #(
        .Channels      (CH),
        .PayloadBytes  (PB),
        .TimeoutCycles (TO),
        .TimeoutBits   (20)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b0;
    endtask

    // Header, optional gap, payload bytes (MSB first), checksum when enabled.
    task automatic send_frame(input logic [7:0] hdr, input logic [15:0] pl, input int npl, input int gap);
        logic [7:0] cs;
        logic [7:0] b;
        cs = hdr;
        send_byte(hdr);
        repeat (gap) @(posedge clk);
        for (int i = 0; i < npl; i++) begin
            b  = pl[15-8*i -: 8];
            cs = cs ^ b;
            send_byte(b);
        end
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    // Called right after the last frame byte: reply must appear exactly at N+2.
    task automatic finish_frame(input string tag, input logic [7:0] data, input logic [3:0] st,
                                input logic [3:0] ab, input logic [3:0] busy, input logic [15:0] arg,
                                input logic [3:0] exec_done);
        bus.done_i = exec_done;
        @(negedge clk);
        check_eq({tag, "_stt_n1"}, bus.tx_stt_o, 0);
        @(posedge clk); #1;
        bus.done_i = '0;
        @(negedge clk);
        check_eq({tag, "_stt"},   bus.tx_stt_o, 1);
        check_eq({tag, "_data"},  bus.tx_data_o, data);
        check_eq({tag, "_start"}, bus.start_o, st);
        check_eq({tag, "_abort"}, bus.abort_o, ab);
        check_eq({tag, "_busy"},  bus.busy_o, busy);
        check_eq({tag, "_arg"},   bus.arg_o, arg);
    endtask

    task automatic send_eot();
        @(posedge clk); #1;
        bus.tx_eot_i = 1'b1;
        @(posedge clk); #1;
        bus.tx_eot_i = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [7:0] hdr, input logic [15:0] pl, input int npl,
                       input logic [7:0] data, input logic [3:0] st, input logic [3:0] ab,
                       input logic [3:0] busy, input logic [15:0] arg, input logic [3:0] exec_done);
        send_frame(hdr, pl, npl, 0);
        finish_frame(tag, data, st, ab, busy, arg, exec_done);
        send_eot();
    endtask

    initial begin
        int seen_err;
        int seen_stt;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.tx_eot_i   = 1'b0;
        bus.done_i     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_stt",   bus.tx_stt_o, 0);
        check_eq("rst_data",  bus.tx_data_o, 8'h00);
        check_eq("rst_start", bus.start_o, 0);
        check_eq("rst_abort", bus.abort_o, 0);
        check_eq("rst_arg",   bus.arg_o, 0);
        check_eq("rst_busy",  bus.busy_o, 0);
        check_eq("rst_err",   bus.err_o, 0);

        txn("ping",     8'h00, 16'h0000, 0, 8'h06, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000);
        txn("run2",     8'h42, 16'h1234, 2, 8'h06, 4'b0100, 4'b0000, 4'b0100, 16'h1234, 4'b0000);
        txn("run2_bsy", 8'h42, 16'h5678, 2, 8'h15, 4'b0000, 4'b0000, 4'b0100, 16'h1234, 4'b0000);

        @(posedge clk); #1 bus.done_i = 4'b0100;
        @(posedge clk); #1 bus.done_i = 4'b0000;
        @(negedge clk);
        check_eq("done2_busy", bus.busy_o, 0);

        txn("stat0", 8'h80, 16'h0000, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 16'h1234, 4'b0000);
        txn("run1",  8'h41, 16'hABCD, 2, 8'h06, 4'b0010, 4'b0000, 4'b0010, 16'hABCD, 4'b0000);
        txn("stat1", 8'h80, 16'h0000, 0, 8'h02, 4'b0000, 4'b0000, 4'b0010, 16'hABCD, 4'b0000);

        // Refused headers reply at once, never collecting payload or checksum.
        send_byte(8'h47);
        finish_frame("bad_ch", 8'h15, 4'b0000, 4'b0000, 4'b0010, 16'hABCD, 4'b0000);
        send_eot();
        send_byte(8'h08);
        finish_frame("bad_rsv", 8'h15, 4'b0000, 4'b0000, 4'b0010, 16'hABCD, 4'b0000);
        send_eot();

        txn("abort1",   8'hC1, 16'h0000, 0, 8'h06, 4'b0000, 4'b0010, 4'b0000, 16'hABCD, 4'b0000);
        txn("abort3i",  8'hC3, 16'h0000, 0, 8'h06, 4'b0000, 4'b1000, 4'b0000, 16'hABCD, 4'b0000);
        txn("run3_dn",  8'h43, 16'h0001, 2, 8'h06, 4'b1000, 4'b0000, 4'b1000, 16'h0001, 4'b1000);
        txn("abrt3_dn", 8'hC3, 16'h0000, 0, 8'h06, 4'b0000, 4'b1000, 4'b0000, 16'h0001, 4'b1000);

        // Stalled RUN frame: exactly one err pulse and no reply.
        send_byte(8'h42);
        seen_err = 0;
        seen_stt = 0;
        repeat (TO + 10) begin
            @(negedge clk);
            if (bus.err_o)    seen_err++;
            if (bus.tx_stt_o) seen_stt++;
        end
        check_eq("tmo_err", seen_err, 1);
        check_eq("tmo_stt", seen_stt, 0);
        txn("ping_tmo", 8'h00, 16'h0000, 0, 8'h06, 4'b0000, 4'b0000, 4'b0000, 16'h0001, 4'b0000);

        // Gap just inside the limit must not time out.
        send_frame(8'h40, 16'h9ABC, 2, TO - 4);
        finish_frame("run0_gap", 8'h06, 4'b0001, 4'b0000, 4'b0001, 16'h9ABC, 4'b0000);
        send_eot();

        // Byte arriving during TX is dropped with an error pulse.
        send_frame(8'h00, 16'h0000, 0, 0);
        finish_frame("ping_tx", 8'h06, 4'b0000, 4'b0000, 4'b0001, 16'h9ABC, 4'b0000);
        send_byte(8'h55);
        @(negedge clk);
        check_eq("drop_err", bus.err_o, 1);

        // Header presented in the very first IDLE cycle after tx_eot_i.
        @(posedge clk); #1 bus.tx_eot_i = 1'b1;
        @(posedge clk); #1;
        bus.tx_eot_i   = 1'b0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h00;
        @(posedge clk); #1 bus.rx_valid_i = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h00);
`endif
        finish_frame("ping_imm", 8'h06, 4'b0000, 4'b0000, 4'b0001, 16'h9ABC, 4'b0000);
        send_eot();

`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h41); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        finish_frame("cs_bad", 8'h15, 4'b0000, 4'b0000, 4'b0001, 16'h9ABC, 4'b0000);
        send_eot();
        send_byte(8'h41); send_byte(8'hAA); send_byte(8'h55); send_byte(8'hBE);
        finish_frame("cs_good", 8'h06, 4'b0010, 4'b0000, 4'b0011, 16'hAA55, 4'b0000);
        send_eot();
`endif

        // Reset in the middle of a frame clears all state.
        send_byte(8'h42);
        send_byte(8'h12);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_arg",  bus.arg_o, 0);
        check_eq("mrst_busy", bus.busy_o, 0);
        check_eq("mrst_stt",  bus.tx_stt_o, 0);
        txn("ping_mrst", 8'h00, 16'h0000, 0, 8'h06, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
